// File: rtl/cgra_pkg.sv
// Shared types and defaults for the CGRA vector-add scheduler.
package cgra_pkg;

    localparam int CGRA_DEPTH        = 32;
    localparam int CGRA_MAX_INFLIGHT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/cgra_credit_ctr.sv
// Credit pool bounding the number of adder operations in flight.
// A credit returned in the same cycle can be spent immediately, so a pool
// of MAX credits sustains one issue per clock when the loop latency <= MAX.
module cgra_credit_ctr #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic take_i,
    input  logic give_i,
    output logic avail_o,
    output logic full_o
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Net credit change; simultaneous take and give cancel out.
    always_comb begin
        count_d = count_q;
        if (take_i && !give_i && (count_q != '0)) begin
            count_d = count_q - ONE_C;
        end else if (give_i && !take_i && (count_q != MAX_C)) begin
            count_d = count_q + ONE_C;
        end
    end

    // Credit register, refilled to the full pool on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= MAX_C;
        end else begin
            count_q <= count_d;
        end
    end

    assign avail_o = (count_q != '0) || give_i;
    assign full_o  = (count_q == MAX_C);

endmodule

// File: rtl/cgra_vadd_sched.sv
// Sequencer streaming operand pairs through the pipelined CGRA adder and
// writing each sum back in order, with credit-limited issue.
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// ISSUE | reading operands and feeding the adder
// DRAIN | all operands issued, waiting for remaining results
// DONE  | one-cycle done pulse, then back to IDLE
module cgra_vadd_sched
    import cgra_pkg::*;
#(
    parameter int DEPTH        = CGRA_DEPTH,
    parameter int MAX_INFLIGHT = CGRA_MAX_INFLIGHT,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          dp_valid_o,
    input  logic          dp_ready_i,
    input  logic          res_valid_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          err_unexp_o
);

    localparam int          CNTW    = AW + 1;
    localparam logic [AW:0] DEPTH_C = CNTW'(DEPTH);

    sched_state_e state_q;
    logic [AW:0]  len_q;
    logic [AW:0]  issued_q;
    logic [AW:0]  issued_d;
    logic [AW:0]  written_q;
    logic [AW:0]  written_d;
    logic [AW:0]  len_eff;
    logic         busy_q;
    logic         done_q;
    logic         dp_valid_q;
    logic         err_q;
    logic         rd_en;
    logic         wr_en;
    logic         credit_avail;
    logic         credit_full;

    assign len_eff   = (len_i > DEPTH_C) ? DEPTH_C : len_i;

    // A stalled operand pair in front of the adder blocks the next read.
    assign rd_en     = (state_q == ISSUE) && (issued_q < len_q) && credit_avail
                       && !(dp_valid_q && !dp_ready_i);
    assign wr_en     = res_valid_i && busy_q;
    assign issued_d  = issued_q + {{AW{1'b0}}, rd_en};
    assign written_d = written_q + {{AW{1'b0}}, wr_en};

    cgra_credit_ctr #(
        .MAX (MAX_INFLIGHT)
    ) u_credit (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .take_i  (rd_en),
        .give_i  (wr_en),
        .avail_o (credit_avail),
        .full_o  (credit_full)
    );

    // Sequencer FSM with issue/write counters and registered busy/done.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            issued_q  <= issued_d;
            written_q <= written_d;
            done_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        len_q <= len_eff;
                        if (len_eff == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issued_d == len_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Look at the post-write count so done follows the last write directly.
                    if (written_d == len_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    issued_q  <= '0;
                    written_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand-valid flag: set by a read, held until the adder accepts it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dp_valid_q <= 1'b0;
        end else if (rd_en) begin
            dp_valid_q <= 1'b1;
        end else if (dp_ready_i) begin
            dp_valid_q <= 1'b0;
        end
    end

    // Sticky flag for results arriving when nothing is outstanding.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (res_valid_i && (!busy_q || credit_full)) begin
            err_q <= 1'b1;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign rd_en_o     = rd_en;
    assign rd_addr_o   = issued_q[AW-1:0];
    assign dp_valid_o  = dp_valid_q;
    assign wr_en_o     = wr_en;
    assign wr_addr_o   = written_q[AW-1:0];
    assign err_unexp_o = err_q;

endmodule
